// File: rtl/riscv_pkg.sv
// Shared RISC-V constants used by the fetch front end.
package riscv_pkg;

   localparam int XLEN = 32;

   // add x0,x0,x0 -- shown to IF/ID whenever no fetched word is available
   localparam logic [31:0] NOP = 32'h0000_0033;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry storage: DEPTH x W register array, one write port, one asynchronous read port.
module fq_storage
   import riscv_pkg::*;
#(
   parameter int W     = 2 * XLEN,
   parameter int DEPTH = 4,
   parameter int PW    = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [PW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [PW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   // Contents are never reset; entries outside the valid window are masked by the queue logic.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: prefetches sequential words from unified memory and presents the head to IF/ID.
module fetch_queue
   import riscv_pkg::*;
#(
   parameter int n     = XLEN,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   output logic         mem_req,
   output logic [n-1:0] mem_addr,
   input  logic         mem_ready,
   input  logic [n-1:0] mem_rdata,
   input  logic         redirect,
   input  logic [n-1:0] redirect_pc,
   input  logic         stall,
   output logic [n-1:0] inst,
   output logic [n-1:0] pc,
   output logic [n-1:0] pc_plus4,
   output logic         inst_valid
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [n-1:0]  NOP_N    = n'(NOP);
   localparam logic [n-1:0]  FOUR     = n'(4);
   localparam logic [n-1:0]  LOW_MASK = n'(3);

   logic [n-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          push;
   logic          pop;
   logic [2*n-1:0] wr_entry;
   logic [2*n-1:0] rd_entry;
   logic [n-1:0]  head_pc;
   logic [n-1:0]  head_inst;

   assign inst_valid = (count_q != '0);
   assign mem_req    = (count_q < FULL) && !redirect;
   assign mem_addr   = fetch_pc_q;
   assign push       = mem_req && mem_ready;
   assign pop        = inst_valid && !stall && !redirect;
   assign wr_entry   = {fetch_pc_q, mem_rdata};

   fq_storage #(
      .W     (2 * n),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_storage (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   assign head_pc   = rd_entry[2*n-1:n];
   assign head_inst = rd_entry[n-1:0];

   // An empty queue shows a NOP at the address that will be fetched next.
   always_comb begin
      inst = NOP_N;
      pc   = fetch_pc_q;
      if (inst_valid) begin
         inst = head_inst;
         pc   = head_pc;
      end
   end

   assign pc_plus4 = pc + FOUR;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc & ~LOW_MASK;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + FOUR;
            wr_ptr_d   = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, a mid-operation reset pulse,
// then randomized traffic compared against a queue-based reference model.
module tb_fetch_queue;

   localparam int N     = 32;
   localparam int DEPTH = 4;
   localparam logic [31:0] NOP_WORD = 32'h0000_0033;

   logic          clk;
   logic          rst;
   logic          mem_req;
   logic [N-1:0]  mem_addr;
   logic          mem_ready;
   logic [N-1:0]  mem_rdata;
   logic          redirect;
   logic [N-1:0]  redirect_pc;
   logic          stall;
   logic [N-1:0]  inst;
   logic [N-1:0]  pc;
   logic [N-1:0]  pc_plus4;
   logic          inst_valid;

   int errors = 0;
   int checks = 0;

   fetch_queue #(.n(N), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .inst        (inst),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .inst_valid  (inst_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        ready;
      logic        stall;
      logic        redirect;
      logic [31:0] redirect_pc;
      logic [31:0] rdata;
      logic        exp_valid;
      logic [31:0] exp_inst;
      logic [31:0] exp_pc;
      logic        exp_req;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[13];

   // Reference model: the queue contents as plain lists plus the next fetch address.
   logic [31:0] model_pc[$];
   logic [31:0] model_inst[$];
   logic [31:0] model_fetch_pc;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkAll(input logic valid, input logic [31:0] exp_inst, input logic [31:0] exp_pc,
                           input logic req, input logic [31:0] addr, input string tag);
      checkOutput({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, valid});
      checkOutput({tag, ".inst"}, inst, exp_inst);
      checkOutput({tag, ".pc"}, pc, exp_pc);
      checkOutput({tag, ".pc_plus4"}, pc_plus4, exp_pc + 32'd4);
      checkOutput({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, req});
      checkOutput({tag, ".mem_addr"}, mem_addr, addr);
   endtask

   task automatic applyStimulus(input logic ready, input logic stl, input logic redir,
                                input logic [31:0] rpc, input logic [31:0] rdata);
      mem_ready   = ready;
      stall       = stl;
      redirect    = redir;
      redirect_pc = rpc;
      mem_rdata   = rdata;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic modelStep();
      logic        valid;
      logic        req;
      logic [31:0] exp_inst;
      logic [31:0] exp_pc;
      logic        popped;
      logic        granted;
      valid    = (model_pc.size() != 0);
      req      = (model_pc.size() < DEPTH) && !redirect;
      exp_inst = valid ? model_inst[0] : NOP_WORD;
      exp_pc   = valid ? model_pc[0] : model_fetch_pc;
      #1;
      checkAll(valid, exp_inst, exp_pc, req, model_fetch_pc, "rand");
      popped  = valid && !stall;
      granted = req && mem_ready;
      nextCycle();
      if (redirect) begin
         model_pc.delete();
         model_inst.delete();
         model_fetch_pc = {redirect_pc[31:2], 2'b00};
      end else begin
         if (popped) begin
            void'(model_pc.pop_front());
            void'(model_inst.pop_front());
         end
         if (granted) begin
            model_pc.push_back(model_fetch_pc);
            model_inst.push_back(mem_rdata);
            model_fetch_pc = model_fetch_pc + 32'd4;
         end
      end
   endtask

   initial begin
      //            ready stall redir rpc          rdata         valid inst          pc            req addr
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'hA000_0000, 1'b0, NOP_WORD,      32'h000,      1'b1, 32'h000};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'hA000_0004, 1'b1, 32'hA000_0000, 32'h000,      1'b1, 32'h004};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'hA000_0008, 1'b1, 32'hA000_0000, 32'h000,      1'b1, 32'h008};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'hA000_000C, 1'b1, 32'hA000_0000, 32'h000,      1'b1, 32'h00C};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'hDEAD_0010, 1'b1, 32'hA000_0000, 32'h000,      1'b0, 32'h010};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'hDEAD_0010, 1'b1, 32'hA000_0000, 32'h000,      1'b0, 32'h010};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h103,     32'hDEAD_0010, 1'b1, 32'hA000_0000, 32'h000,      1'b0, 32'h010};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'hDEAD_0100, 1'b0, NOP_WORD,      32'h100,      1'b1, 32'h100};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,       32'hB000_0100, 1'b0, NOP_WORD,      32'h100,      1'b1, 32'h100};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'hDEAD_0104, 1'b1, 32'hB000_0100, 32'h100,      1'b1, 32'h104};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,       32'hDEAD_0104, 1'b0, NOP_WORD,      32'h104,      1'b1, 32'h104};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h202,     32'hDEAD_0104, 1'b0, NOP_WORD,      32'h104,      1'b0, 32'h104};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,       32'hDEAD_0200, 1'b0, NOP_WORD,      32'h200,      1'b1, 32'h200};

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      checkAll(1'b0, NOP_WORD, 32'h0, 1'b1, 32'h0, "in_reset");
      nextCycle();
      nextCycle();
      rst = 1'b0;
      #1;
      checkAll(1'b0, NOP_WORD, 32'h0, 1'b1, 32'h0, "after_reset");

      // Directed table: fill under stall, hold full, redirect, drain, redirect with grant on empty queue.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].ready, vecs[i].stall, vecs[i].redirect, vecs[i].redirect_pc, vecs[i].rdata);
         #1;
         checkAll(vecs[i].exp_valid, vecs[i].exp_inst, vecs[i].exp_pc, vecs[i].exp_req, vecs[i].exp_addr,
                  $sformatf("vec%0d", i));
         nextCycle();
      end

      // Three entries queued under stall, then a half-cycle reset pulse between clock edges.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'hC000_0000 + 32'(i));
         nextCycle();
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      #1;
      checkAll(1'b1, 32'hC000_0000, 32'h200, 1'b1, 32'h20C, "pre_pulse");
      rst = 1'b1;
      #1;
      checkAll(1'b0, NOP_WORD, 32'h0, 1'b1, 32'h0, "async_reset");
      #2;
      rst = 1'b0;
      nextCycle();
      checkAll(1'b0, NOP_WORD, 32'h0, 1'b1, 32'h0, "post_pulse");

      // Randomized traffic against the reference model, starting from the empty reset state.
      model_pc.delete();
      model_inst.delete();
      model_fetch_pc = 32'h0;
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) < 3),
                       ($urandom_range(0, 19) == 0),
                       $urandom(),
                       $urandom());
         modelStep();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter n, default 32, instruction/address width in bits.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mem_req  output  1  fetch request to unified memory.
REQ-006 mem_addr  output  n  word-aligned fetch address.
REQ-007 mem_ready  input  1  memory grants the instruction port this cycle; the data port has priority.
REQ-008 mem_rdata  input  n  fetched instruction; valid in any cycle where mem_req and mem_ready are both high.
REQ-009 redirect  input  1  branch/jump taken (PCSrc); flushes the queue.
REQ-010 redirect_pc  input  n  new fetch target.
REQ-011 stall  input  1  pipeline holds IF/ID (hazard stall or halt).
REQ-012 inst  output  n  head instruction for IF/ID.
REQ-013 pc  output  n  address of the head instruction.
REQ-014 pc_plus4  output  n  pc + 4.
REQ-015 inst_valid  output  1  head entry is valid.

Function
REQ-016 Each entry SHALL hold a {pc, instruction} pair; storage is DEPTH x 2n bits.
REQ-017 State SHALL consist of fetch_pc (n bits), wr_ptr and rd_ptr (log2(DEPTH) bits each) and count (log2(DEPTH)+1 bits).
REQ-018 mem_req SHALL be high exactly when count < DEPTH and redirect is low; mem_addr SHALL equal fetch_pc.
REQ-019 Push: when mem_req and mem_ready are both high, the block SHALL write {fetch_pc, mem_rdata} at wr_ptr, increment wr_ptr modulo DEPTH, and advance fetch_pc by 4 (modulo 2^n).
REQ-020 Pop: when inst_valid is high and stall is low, the block SHALL increment rd_ptr modulo DEPTH.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; push alone SHALL increment count; pop alone SHALL decrement it.
REQ-022 inst_valid SHALL equal (count != 0); inst, pc and pc_plus4 SHALL be combinational from the rd_ptr entry (latency 0 from head to output).
REQ-023 When the queue is empty, the outputs SHALL be: inst = 0x00000033 (NOP, add x0,x0,x0), pc = fetch_pc, pc_plus4 = fetch_pc + 4.
REQ-024 A fetched word SHALL first appear at the outputs the cycle after its push; there is no same-cycle bypass.
REQ-025 Full (count == DEPTH): mem_req SHALL be low, and no push SHALL occur even if mem_ready is high.
REQ-026 Redirect SHALL have priority over every other event: count, wr_ptr and rd_ptr SHALL be cleared, and fetch_pc SHALL be loaded with {redirect_pc[n-1:2], 2'b00}.
REQ-027 During a redirect cycle, a same-cycle grant SHALL be discarded and no pop SHALL occur.
REQ-028 During a redirect cycle, the outputs SHALL show the NOP/invalid values from the next cycle onward.
REQ-029 Stall SHALL NOT block fetching; fetching continues until the queue is full.
REQ-030 Storage contents of invalid entries are don't-care and SHALL never be visible at the outputs.

Reset
REQ-031 While rst is high, asynchronously: fetch_pc = 0, wr_ptr = 0, rd_ptr = 0, count = 0.
REQ-032 Outputs during and immediately after reset: inst_valid = 0, inst = NOP, pc = 0, pc_plus4 = 4, mem_req = 1, mem_addr = 0.
REQ-033 Reset asserted mid-operation SHALL drop all queued entries; any grant in flight is discarded.
REQ-034 Storage array contents need not be reset.

Structure
REQ-035 The shared package riscv_pkg SHALL hold the NOP constant (32'h00000033) and the XLEN width constant.
REQ-036 Storage SHALL be one sub-module, fq_storage: a register array with one write port and one asynchronous read port.
REQ-037 The pointer, count and fetch_pc logic SHALL reside in fetch_queue.

Verification
REQ-038 Reset, then mem_ready = 1 and stall = 0 continuously -> mem_addr 0, 4, 8 on successive cycles; pc at the output = 0 one cycle after the first grant; inst_valid stays high thereafter.
REQ-039 stall = 1 with mem_ready = 1, DEPTH = 4 -> four pushes (addresses 0, 4, 8, 12), then count = 4 and mem_req = 0; the head stays at pc 0 for as long as stall is held.
REQ-040 Full queue, redirect = 1 with redirect_pc = 0x103 -> next cycle: inst_valid = 0, inst = 0x00000033, mem_addr = 0x100; the following grant delivers pc 0x100.
REQ-041 redirect and mem_ready both high, with the queue empty -> no entry is written; count = 0 the next cycle.
REQ-042 mem_ready toggled 1/0 with stall = 0 -> pops never exceed pushes, count never wraps below 0, and the pc sequence is gap-free (0, 4, 8, ...).
REQ-043 rst pulsed for half a cycle while count = 3 -> count = 0, fetch_pc = 0 and inst_valid = 0 immediately, without waiting for a clock edge.
